// File: rtl/bmc_rx_adaptive.sv
// rtl/bmc_rx_adaptive.sv - BMC receiver with edge-interval decoding and bit-period tracking
module bmc_rx_adaptive #(
   parameter int SYSTEM_KHZ  = 30000,
   parameter int BIT_KBPS    = 300,
   parameter int FILTER_LEN  = 3,
   parameter int CNT_W       = 12,
   parameter int TRACK_SHIFT = 3
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             enable,
   input  logic             bmc_in,
   output logic             bit_valid,
   output logic             bit_data,
   output logic             pkt_active,
   output logic             eop,
   output logic             err,
   output logic [CNT_W-1:0] ui_est
);

   localparam int DIV    = SYSTEM_KHZ / BIT_KBPS;
   localparam int UI_MIN = DIV - DIV / 4;
   localparam int UI_MAX = DIV + DIV / 4;
   localparam int XW     = CNT_W + 3;
   localparam logic signed [XW:0] UI_LO = UI_MIN[XW:0];
   localparam logic signed [XW:0] UI_HI = UI_MAX[XW:0];

   typedef enum logic [1:0] {IDLE, FULL, HALF} state_t;

   state_t                  state, state_n;
   logic                    sync1;
   logic [FILTER_LEN-1:0]   samp;
   logic                    filt, filt_d, line_edge;
   logic [CNT_W-1:0]        cnt, first_short, first_n, ui_n;
   logic [XW-1:0]           u_x, cnt_x, short_lo, short_hi, long_hi, timeout_x;
   logic                    is_short, is_long, timeout;
   logic                    bit_valid_n, bit_data_n, err_n, eop_n;

   // samp[0] is the second synchroniser stage; older samples shift upward
   always_ff @(posedge clock) begin
      sync1 <= bmc_in;
      samp  <= (samp << 1) | FILTER_LEN'(sync1);
      if (rst) begin
         filt   <= samp[0];
         filt_d <= samp[0];
      end else begin
         if (&samp)
            filt <= 1'b1;
         else if (~|samp)
            filt <= 1'b0;
         filt_d <= filt;
      end
   end

   assign line_edge = filt != filt_d;

   // cnt counts clocks since the previous edge, so at an edge it equals the interval
   always_ff @(posedge clock) begin
      if (rst || !enable)
         cnt <= '0;
      else if (line_edge)
         cnt <= CNT_W'(1);
      else if (cnt != '1)
         cnt <= cnt + 1'b1;
   end

   always_comb begin
      u_x       = XW'(ui_est);
      cnt_x     = XW'(cnt);
      short_lo  = u_x >> 2;
      short_hi  = (u_x + (u_x << 1)) >> 2;
      long_hi   = (u_x + (u_x << 2)) >> 2;
      timeout_x = u_x + (u_x >> 1);
      is_short  = (cnt_x >= short_lo) && (cnt_x < short_hi);
      is_long   = (cnt_x >= short_hi) && (cnt_x <= long_hi);
      timeout   = cnt_x == timeout_x;
   end

   function automatic logic [CNT_W-1:0] track(input logic [XW-1:0] meas,
                                              input logic [CNT_W-1:0] u);
      logic signed [XW:0] cur, nxt;
      cur = signed'({1'b0, XW'(u)});
      nxt = cur + ((signed'({1'b0, meas}) - cur) >>> TRACK_SHIFT);
      if (nxt < UI_LO)
         nxt = UI_LO;
      else if (nxt > UI_HI)
         nxt = UI_HI;
      return CNT_W'(nxt);
   endfunction

   always_ff @(posedge clock) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (!enable)
         state_n = IDLE;
      else begin
         case (state)
            IDLE: if (line_edge) state_n = FULL;
            FULL: begin
               if (line_edge) begin
                  if (is_short) state_n = HALF;
               end else if (timeout)
                  state_n = IDLE;
            end
            HALF: begin
               if (line_edge)
                  state_n = FULL;
               else if (timeout)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      bit_valid_n = 1'b0;
      bit_data_n  = 1'b0;
      err_n       = 1'b0;
      eop_n       = 1'b0;
      ui_n        = ui_est;
      first_n     = first_short;
      if (!enable)
         ui_n = CNT_W'(DIV);
      else begin
         case (state)
            FULL: begin
               if (line_edge) begin
                  if (is_long) begin
                     bit_valid_n = 1'b1;
                     if (TRACK_SHIFT > 0) ui_n = track(cnt_x, ui_est);
                  end else if (is_short)
                     first_n = cnt;
                  else
                     err_n = 1'b1;
               end else if (timeout) begin
                  eop_n = 1'b1;
                  ui_n  = CNT_W'(DIV);
               end
            end
            HALF: begin
               if (line_edge) begin
                  if (is_short) begin
                     bit_valid_n = 1'b1;
                     bit_data_n  = 1'b1;
                     if (TRACK_SHIFT > 0) ui_n = track(cnt_x + XW'(first_short), ui_est);
                  end else
                     err_n = 1'b1;
               end else if (timeout) begin
                  eop_n = 1'b1;
                  ui_n  = CNT_W'(DIV);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         bit_valid   <= 1'b0;
         bit_data    <= 1'b0;
         err         <= 1'b0;
         eop         <= 1'b0;
         ui_est      <= CNT_W'(DIV);
         first_short <= '0;
      end else begin
         bit_valid   <= bit_valid_n;
         bit_data    <= bit_data_n;
         err         <= err_n;
         eop         <= eop_n;
         ui_est      <= ui_n;
         first_short <= first_n;
      end
   end

   assign pkt_active = state != IDLE;

endmodule
